// File: rtl/mko_pkg.sv
// Shared types and constants for the MKO bus transaction sequencer.
package mko_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    localparam logic [4:0] MKO_ALL_OFF = 5'b11111;
    localparam int         MIN_STRB    = 2;
    localparam logic       RDWR_READ   = 1'b1;

endpackage

// File: rtl/mko_rdy_sync.sv
// Two-flop synchronizer for the per-device READYD_N lines (idle high).
module mko_rdy_sync #(
    parameter int NUM_MKO = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_MKO-1:0] async_i,
    output logic [NUM_MKO-1:0] sync_o
);

    logic [NUM_MKO-1:0] meta_q;
    logic [NUM_MKO-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/mko_bus_seq.sv
// Single-request sequencer driving SELECT/STROBE/RDWR/ADR/DATA for the MKO devices,
// waiting on the selected device's ready with a bounded strobe.
module mko_bus_seq
    import mko_pkg::*;
#(
    parameter int NUM_MKO     = 5,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int SETUP_CYC   = 1,
    parameter int HOLD_CYC    = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               CLK_16,
    input  logic               RESET,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_sel,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               busy,
    output logic [NUM_MKO-1:0] MKO_SELECT_N,
    output logic [NUM_MKO-1:0] MKO_STRBD_N,
    output logic               MKO_RDWR_N,
    output logic [ADDR_W-1:0]  ADR_MKO,
    output logic [DATA_W-1:0]  DATA_MKO_O,
    output logic               DATA_MKO_OE,
    input  logic [DATA_W-1:0]  DATA_MKO_I,
    input  logic [NUM_MKO-1:0] MKO_READYD_N
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    function automatic logic [NUM_MKO-1:0] low_at(input logic [2:0] s);
        logic [NUM_MKO-1:0] v;
        v    = '1;
        v[s] = 1'b0;
        return v;
    endfunction

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [2:0]         sel_q;
    logic               res_err_q;
    logic [DATA_W-1:0]  res_rdata_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic [NUM_MKO-1:0] sel_n_q;
    logic [NUM_MKO-1:0] strb_n_q;
    logic               rdwr_n_q;
    logic [ADDR_W-1:0]  adr_q;
    logic [DATA_W-1:0]  dout_q;
    logic               oe_q;
    logic [NUM_MKO-1:0] rdy_sync;
    logic               done;

    mko_rdy_sync #(.NUM_MKO(NUM_MKO)) u_sync (
        .clk_i  (CLK_16),
        .rst_i  (RESET),
        .async_i(MKO_READYD_N),
        .sync_o (rdy_sync)
    );

    // The minimum strobe length hides a ready left low by the previous access.
    assign done = !rdy_sync[sel_q] && (cnt_q >= CNT_W'(MIN_STRB));

    always_ff @(posedge CLK_16 or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            res_err_q   <= 1'b0;
            res_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            sel_n_q     <= MKO_ALL_OFF;
            strb_n_q    <= MKO_ALL_OFF;
            rdwr_n_q    <= RDWR_READ;
            adr_q       <= '0;
            dout_q      <= '0;
            oe_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q  <= req_we;
                        sel_q <= req_sel;
                        cnt_q <= '0;
                        if (int'(req_sel) >= NUM_MKO) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q  <= SETUP;
                            sel_n_q  <= low_at(req_sel);
                            rdwr_n_q <= ~req_we;
                            adr_q    <= req_addr;
                            if (req_we) begin
                                oe_q   <= 1'b1;
                                dout_q <= req_wdata;
                            end
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                        state_q  <= STROBE;
                        strb_n_q <= low_at(sel_q);
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STROBE: begin
                    if (done || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q     <= HOLD;
                        strb_n_q    <= MKO_ALL_OFF;
                        cnt_q       <= '0;
                        res_err_q   <= !done;
                        res_rdata_q <= (done && !we_q) ? DATA_MKO_I : '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= res_err_q;
                        rsp_rdata_q <= res_rdata_q;
                        sel_n_q     <= MKO_ALL_OFF;
                        rdwr_n_q    <= RDWR_READ;
                        oe_q        <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign MKO_SELECT_N = sel_n_q;
    assign MKO_STRBD_N  = strb_n_q;
    assign MKO_RDWR_N   = rdwr_n_q;
    assign ADR_MKO      = adr_q;
    assign DATA_MKO_O   = dout_q;
    assign DATA_MKO_OE  = oe_q;

endmodule

// File: tb/tb_mko_bus_seq.sv
// Directed bench for mko_bus_seq: write, read, timeout, bad index,
// foreign ready and asynchronous reset in the middle of a strobe.
module tb_mko_bus_seq;

    logic        CLK_16 = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_sel;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [4:0]  MKO_SELECT_N;
    logic [4:0]  MKO_STRBD_N;
    logic        MKO_RDWR_N;
    logic [15:0] ADR_MKO;
    logic [15:0] DATA_MKO_O;
    logic        DATA_MKO_OE;
    logic [15:0] DATA_MKO_I;
    logic [4:0]  MKO_READYD_N;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int          sel_low, strb_low, oe_cnt, rsp_cyc;
    logic        multi, r_err, first_rdwr, first_oe, end_oe, end_rdwr;
    logic [4:0]  sel_pat, strb_pat, end_sel;
    logic [15:0] r_rdata, first_adr, first_dout;

    always #5 CLK_16 = ~CLK_16;

    mko_bus_seq dut (
        .CLK_16      (CLK_16),
        .RESET       (RESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_sel     (req_sel),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .busy        (busy),
        .MKO_SELECT_N(MKO_SELECT_N),
        .MKO_STRBD_N (MKO_STRBD_N),
        .MKO_RDWR_N  (MKO_RDWR_N),
        .ADR_MKO     (ADR_MKO),
        .DATA_MKO_O  (DATA_MKO_O),
        .DATA_MKO_OE (DATA_MKO_OE),
        .DATA_MKO_I  (DATA_MKO_I),
        .MKO_READYD_N(MKO_READYD_N)
    );

    task automatic tick();
        @(posedge CLK_16);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and watch the bus cycle by cycle until rsp_valid.
    // When rdy_at >= 0, READYD_N[rdy_bit] is pulled low in strobe cycle rdy_at.
    task automatic run(input logic we, input logic [2:0] sel, input logic [15:0] addr,
                       input logic [15:0] wdata, input int rdy_at, input int rdy_bit);
        int  cyc;
        bit  got;
        req_we    = we;
        req_sel   = sel;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        sel_low = 0; strb_low = 0; oe_cnt = 0; rsp_cyc = 0; multi = 1'b0;
        sel_pat = 5'h1f; strb_pat = 5'h1f;
        cyc = 1; got = 0;
        while (!got && cyc < 200) begin
            if (cyc == 1) begin
                first_adr  = ADR_MKO;
                first_dout = DATA_MKO_O;
                first_rdwr = MKO_RDWR_N;
                first_oe   = DATA_MKO_OE;
            end
            if (MKO_SELECT_N != 5'h1f) begin
                sel_low++;
                sel_pat = MKO_SELECT_N;
            end
            if (MKO_STRBD_N != 5'h1f) begin
                strb_low++;
                strb_pat = MKO_STRBD_N;
                if (strb_low == rdy_at + 1) MKO_READYD_N[rdy_bit] = 1'b0;
            end
            if (DATA_MKO_OE) oe_cnt++;
            if ($countones(~MKO_SELECT_N) > 1 || $countones(~MKO_STRBD_N) > 1) multi = 1'b1;
            if (rsp_valid) begin
                got      = 1;
                rsp_cyc  = cyc;
                r_err    = rsp_err;
                r_rdata  = rsp_rdata;
                end_sel  = MKO_SELECT_N;
                end_oe   = DATA_MKO_OE;
                end_rdwr = MKO_RDWR_N;
            end else begin
                tick();
                cyc++;
            end
        end
    endtask

    initial begin
        RESET        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_sel      = '0;
        req_addr     = '0;
        req_wdata    = '0;
        DATA_MKO_I   = '0;
        MKO_READYD_N = 5'b11011;
        #7;
        chk("rst_sel",   32'(MKO_SELECT_N), 32'h1f);
        chk("rst_strb",  32'(MKO_STRBD_N),  32'h1f);
        chk("rst_rdwr",  32'(MKO_RDWR_N),   32'h1);
        chk("rst_oe",    32'(DATA_MKO_OE),  32'h0);
        chk("rst_adr",   32'(ADR_MKO),      32'h0);
        chk("rst_dout",  32'(DATA_MKO_O),   32'h0);
        chk("rst_rsp",   32'({rsp_valid, rsp_err}), 32'h0);
        chk("rst_rdata", 32'(rsp_rdata),    32'h0);
        chk("rst_ready", 32'({req_ready, busy}), 32'h2);
        #10;
        RESET = 1'b0;
        tick(); tick(); tick();

        // Write to device 2, ready already low
        run(1'b1, 3'd2, 16'h0123, 16'hBEEF, -1, 0);
        chk("wr_selpat",  32'(sel_pat),   32'h1b);
        chk("wr_strbpat", 32'(strb_pat),  32'h1b);
        chk("wr_sellow",  32'(sel_low),   32'd5);
        chk("wr_strblow", 32'(strb_low),  32'd3);
        chk("wr_rdwr",    32'(first_rdwr), 32'h0);
        chk("wr_adr",     32'(first_adr), 32'h0123);
        chk("wr_dout",    32'(first_dout), 32'hBEEF);
        chk("wr_oecnt",   32'(oe_cnt),    32'd5);
        chk("wr_rspcyc",  32'(rsp_cyc),   32'd6);
        chk("wr_err",     32'(r_err),     32'h0);
        chk("wr_end",     32'({end_sel, end_oe, end_rdwr}), 32'({5'h1f, 1'b0, 1'b1}));
        chk("wr_busy",    32'(busy),      32'h1);
        tick();
        chk("wr_b2b",     32'({req_ready, rsp_valid}), 32'h2);

        // Read from device 4, ready falls 5 strobe cycles in
        MKO_READYD_N = 5'b11111;
        DATA_MKO_I   = 16'h5A5A;
        tick(); tick(); tick();
        run(1'b0, 3'd4, 16'h0040, 16'h0000, 5, 4);
        chk("rd_strbpat", 32'(strb_pat), 32'h0f);
        chk("rd_strblow", 32'(strb_low), 32'd8);
        chk("rd_rdwr",    32'(first_rdwr), 32'h1);
        chk("rd_oe",      32'(oe_cnt),   32'd0);
        chk("rd_rdata",   32'(r_rdata),  32'h5A5A);
        chk("rd_err",     32'(r_err),    32'h0);
        chk("rd_rspcyc",  32'(rsp_cyc),  32'd11);
        chk("rd_multi",   32'(multi),    32'h0);
        tick();
        chk("rd_hold",    32'({rsp_valid, rsp_rdata}), 32'h05A5A);

        // Timeout on device 0
        MKO_READYD_N = 5'b11111;
        tick(); tick(); tick();
        run(1'b0, 3'd0, 16'h0007, 16'h0000, -1, 0);
        chk("to_strbpat", 32'(strb_pat), 32'h1e);
        chk("to_strblow", 32'(strb_low), 32'd64);
        chk("to_err",     32'(r_err),    32'h1);
        chk("to_rdata",   32'(r_rdata),  32'h0);
        chk("to_rspcyc",  32'(rsp_cyc),  32'd67);
        chk("to_end",     32'({end_sel, end_oe, end_rdwr}), 32'({5'h1f, 1'b0, 1'b1}));
        tick();
        chk("to_errhold", 32'({rsp_valid, rsp_err, req_ready}), 32'h3);

        // Bad device index
        run(1'b1, 3'd6, 16'h1111, 16'h2222, -1, 0);
        chk("bad_rspcyc", 32'(rsp_cyc),  32'd1);
        chk("bad_err",    32'(r_err),    32'h1);
        chk("bad_pins",   32'({sel_low, strb_low}), 32'h0);
        chk("bad_oe",     32'(oe_cnt),   32'd0);
        tick();

        // Ready from a different device must be ignored
        MKO_READYD_N = 5'b11101;
        tick(); tick(); tick();
        run(1'b0, 3'd3, 16'h0300, 16'h0000, -1, 0);
        chk("fr_strbpat", 32'(strb_pat), 32'h17);
        chk("fr_strblow", 32'(strb_low), 32'd64);
        chk("fr_err",     32'(r_err),    32'h1);
        tick();

        // Asynchronous reset while strobing device 1
        MKO_READYD_N = 5'b11111;
        tick(); tick(); tick();
        req_we    = 1'b0;
        req_sel   = 3'd1;
        req_addr  = 16'h0055;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        chk("ar_pre",     32'(MKO_STRBD_N), 32'h1d);
        #2;
        RESET = 1'b1;
        #1;
        chk("ar_strb",    32'(MKO_STRBD_N),  32'h1f);
        chk("ar_sel",     32'(MKO_SELECT_N), 32'h1f);
        chk("ar_state",   32'({req_ready, busy, rsp_valid}), 32'h4);
        chk("ar_bus",     32'({MKO_RDWR_N, DATA_MKO_OE, ADR_MKO}), 32'h20000);
        #1;
        RESET = 1'b0;
        MKO_READYD_N = 5'b11101;
        DATA_MKO_I   = 16'h1234;
        tick();
        chk("ar_norsp1",  32'(rsp_valid), 32'h0);
        tick(); tick();
        chk("ar_norsp2",  32'(rsp_valid), 32'h0);
        run(1'b0, 3'd1, 16'h0056, 16'h0000, -1, 0);
        chk("ar_rspcyc",  32'(rsp_cyc),  32'd6);
        chk("ar_rdata",   32'(r_rdata),  32'h1234);
        chk("ar_err",     32'(r_err),    32'h0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
